// File: rtl/bip_program_loader_pkg.sv
// -----------------------------------------------------------------------------
// bip_program_loader_pkg
// Shared constants for the BIP program loader: opcode set, loader state
// encodings, error codes and the opcode legality helper.
// No ports (package).
// -----------------------------------------------------------------------------
package bip_program_loader_pkg;

  // BIP opcodes, in encoding order. Anything above OP_SUBI is illegal.
  typedef enum logic [4:0] {
    OP_HALT = 5'd0,
    OP_STO  = 5'd1,
    OP_LD   = 5'd2,
    OP_LDI  = 5'd3,
    OP_ADD  = 5'd4,
    OP_ADDI = 5'd5,
    OP_SUB  = 5'd6,
    OP_SUBI = 5'd7
  } opcode_e;

  // Loader FSM encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_HI = 3'd1;
  localparam logic [2:0] ST_WAIT_LO = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_ERROR   = 3'd5;

  // Error codes reported on o_error_code
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OPCODE   = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  function automatic logic opcode_ok(input logic [4:0] op);
    return op <= 5'(OP_SUBI);
  endfunction

endpackage

// File: rtl/bip_program_loader_if.sv
// -----------------------------------------------------------------------------
// bip_program_loader_if
// Groups the loader's byte-stream input, program-memory write port and status
// outputs.
//   master : loader side (consumes start/rx, drives memory write + status)
//   slave  : environment side (drives start/rx, observes memory write + status)
// -----------------------------------------------------------------------------
interface bip_program_loader_if #(
  parameter int NB_BYTE        = 8,
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_ADDR        = 10
);
  logic                      i_start;
  logic [NB_BYTE-1:0]        i_rx_data;
  logic                      i_rx_valid;
  logic                      o_prog_wr_enb;
  logic [NB_ADDR-1:0]        o_prog_addr;
  logic [NB_INSTRUCTION-1:0] o_prog_data;
  logic                      o_busy;
  logic                      o_done;
  logic                      o_cpu_enable;
  logic                      o_error;
  logic [1:0]                o_error_code;
  logic [NB_ADDR:0]          o_instr_count;

  modport master (
    input  i_start, i_rx_data, i_rx_valid,
    output o_prog_wr_enb, o_prog_addr, o_prog_data,
    output o_busy, o_done, o_cpu_enable, o_error, o_error_code, o_instr_count
  );

  modport slave (
    output i_start, i_rx_data, i_rx_valid,
    input  o_prog_wr_enb, o_prog_addr, o_prog_data,
    input  o_busy, o_done, o_cpu_enable, o_error, o_error_code, o_instr_count
  );
endinterface

// File: rtl/bip_program_loader_timeout.sv
// -----------------------------------------------------------------------------
// loader_timeout
// Idle-cycle counter for the program loader. Counts cycles while i_enable is
// high; o_expired flags the cycle that would be the TIMEOUT_CYCLES-th counted
// idle cycle, so the owner can leave on the edge that ends it.
//   i_clock   : clock, rising edge
//   i_reset   : asynchronous reset, active-low
//   i_enable  : count this cycle
//   i_clear   : synchronous clear (wins over enable)
//   o_expired : terminal idle cycle reached
// -----------------------------------------------------------------------------
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_expired = i_enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)
      cnt_d = '0;
    else if (i_enable && (cnt_q != LAST))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/bip_program_loader.sv
// -----------------------------------------------------------------------------
// bip_program_loader
// Writer side of the BIP instruction path. Packs pairs of UART bytes into
// 16-bit instructions {opcode, operand}, writes them to program memory at
// consecutive addresses, stops on HALT and then releases the CPU.
//   i_clock : clock, rising edge
//   i_reset : asynchronous reset, active-low
//   bus     : master modport of bip_program_loader_if
//             in : i_start, i_rx_data, i_rx_valid
//             out: o_prog_wr_enb/o_prog_addr/o_prog_data (memory write),
//                  o_busy, o_done, o_cpu_enable, o_error, o_error_code,
//                  o_instr_count
// -----------------------------------------------------------------------------
module bip_program_loader
  import bip_program_loader_pkg::*;
#(
  parameter int NB_OPCODE      = 5,
  parameter int NB_OPERAND     = 11,
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_BYTE        = 8,
  parameter int NB_ADDR        = 10,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  bip_program_loader_if.master  bus
);

  logic [2:0]          state_q, state_d;
  logic [NB_ADDR-1:0]  addr_q, addr_d;
  logic [NB_ADDR:0]    count_q, count_d;
  logic [NB_BYTE-1:0]  hi_q, hi_d;
  logic [NB_BYTE-1:0]  lo_q, lo_d;
  logic [1:0]          err_q, err_d;

  logic                      tmo_enable, tmo_clear, tmo_expired;
  logic [NB_INSTRUCTION-1:0] word;
  logic [NB_OPCODE-1:0]      word_op, rx_op;
  logic                      in_write;

  assign word    = {hi_q, lo_q};
  assign word_op = word[NB_OPERAND +: NB_OPCODE];
  // Opcode of an incoming high byte sits in its top bits
  assign rx_op   = bus.i_rx_data[NB_BYTE-1 -: NB_OPCODE];

  // Only the byte-waiting states are subject to the inter-byte timeout
  assign tmo_enable = ((state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO)) && !bus.i_rx_valid;

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (tmo_enable),
    .i_clear  (tmo_clear),
    .o_expired(tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    err_d     = err_q;
    tmo_clear = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (bus.i_start) begin
          state_d   = ST_WAIT_HI;
          addr_d    = '0;
          count_d   = '0;
          err_d     = ERR_NONE;
          tmo_clear = 1'b1;
        end
      end

      ST_WAIT_HI: begin
        // A byte on the terminal idle cycle takes priority over the timeout
        if (bus.i_rx_valid) begin
          hi_d      = bus.i_rx_data;
          tmo_clear = 1'b1;
          if (opcode_ok(rx_op)) begin
            state_d = ST_WAIT_LO;
          end else begin
            state_d = ST_ERROR;
            err_d   = ERR_OPCODE;
          end
        end else if (tmo_expired) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end

      ST_WAIT_LO: begin
        if (bus.i_rx_valid) begin
          lo_d      = bus.i_rx_data;
          tmo_clear = 1'b1;
          state_d   = ST_WRITE;
        end else if (tmo_expired) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end

      ST_WRITE: begin
        addr_d  = addr_q + 1'b1;
        count_d = count_q + 1'b1;
        if (word_op == 5'(OP_HALT)) begin
          state_d = ST_DONE;
        end else if (addr_q == {NB_ADDR{1'b1}}) begin
          state_d = ST_ERROR;
          err_d   = ERR_OVERFLOW;
        end else begin
          state_d = ST_WAIT_HI;
          // A byte arriving during the write cycle is the next high byte
          if (bus.i_rx_valid) begin
            hi_d      = bus.i_rx_data;
            tmo_clear = 1'b1;
            if (opcode_ok(rx_op)) begin
              state_d = ST_WAIT_LO;
            end else begin
              state_d = ST_ERROR;
              err_d   = ERR_OPCODE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  // Moore outputs decoded from registered state
  assign in_write          = (state_q == ST_WRITE);
  assign bus.o_prog_wr_enb = in_write;
  assign bus.o_prog_addr   = in_write ? addr_q : '0;
  assign bus.o_prog_data   = in_write ? word : '0;
  assign bus.o_busy        = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO) || in_write;
  assign bus.o_done        = (state_q == ST_DONE);
  assign bus.o_cpu_enable  = (state_q == ST_DONE);
  assign bus.o_error       = (state_q == ST_ERROR);
  assign bus.o_error_code  = err_q;
  assign bus.o_instr_count = count_q;

endmodule

// File: tb/tb_bip_program_loader.sv
module tb_bip_program_loader;
  localparam int NB_ADDR = 2;
  localparam int DEPTH   = 4;
  localparam int TMO     = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bip_program_loader_if #(.NB_BYTE(8), .NB_INSTRUCTION(16), .NB_ADDR(NB_ADDR)) bus ();

  bip_program_loader #(
    .NB_ADDR(NB_ADDR),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus    (bus.master)
  );

  typedef struct packed {
    logic [NB_ADDR-1:0] addr;
    logic [15:0]        data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every memory write must match the oldest expected one
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.o_prog_wr_enb === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %0h@%0h expected no write",
                   bus.o_prog_data, bus.o_prog_addr);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.o_prog_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.o_prog_data), 32'(e.data));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'($urandom);
  endtask

  task automatic do_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("start_busy", 32'(bus.o_busy), 1);
    chk("start_done_clr", 32'(bus.o_done), 0);
    chk("start_err_clr", 32'(bus.o_error), 0);
    chk("start_count_clr", 32'(bus.o_instr_count), 0);
  endtask

  task automatic check_status(input string tag, input bit done, input bit err,
                              input logic [1:0] code, input int cnt);
    chk({tag, "_done"}, 32'(bus.o_done), 32'(done));
    chk({tag, "_cpu_en"}, 32'(bus.o_cpu_enable), 32'(done));
    chk({tag, "_error"}, 32'(bus.o_error), 32'(err));
    chk({tag, "_code"}, 32'(bus.o_error_code), 32'(code));
    chk({tag, "_count"}, 32'(bus.o_instr_count), 32'(cnt));
    chk({tag, "_busy"}, 32'(bus.o_busy), 0);
    chk({tag, "_writes_left"}, 32'(exp_q.size()), 0);
  endtask

  // Reference: a load is a list of words written to consecutive addresses from 0;
  // an illegal opcode aborts before its low byte, HALT finishes the load,
  // and filling the last address without HALT is an overflow.
  task automatic run_program(input string tag, input logic [15:0] words[$], input int gap_max);
    int         addr;
    bit         done, err;
    logic [1:0] code;
    logic [4:0] op;
    addr = 0; done = 0; err = 0; code = 2'b00;
    foreach (words[i]) begin
      op = words[i][15:11];
      send_byte(words[i][15:8]);
      if (op > 5'd7) begin
        err = 1; code = 2'b01;
        break;
      end
      idle($urandom_range(0, gap_max));
      exp_q.push_back('{addr: NB_ADDR'(addr), data: words[i]});
      send_byte(words[i][7:0]);
      addr++;
      if (op == 5'd0) begin
        done = 1;
        break;
      end
      if (addr == DEPTH) begin
        err = 1; code = 2'b10;
        break;
      end
      idle($urandom_range(0, gap_max));
    end
    idle(3);
    check_status(tag, done, err, code, addr);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr"}, 32'(bus.o_prog_wr_enb), 0);
    chk({tag, "_addr"}, 32'(bus.o_prog_addr), 0);
    chk({tag, "_data"}, 32'(bus.o_prog_data), 0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 0);
    chk({tag, "_done"}, 32'(bus.o_done), 0);
    chk({tag, "_cpu_en"}, 32'(bus.o_cpu_enable), 0);
    chk({tag, "_error"}, 32'(bus.o_error), 0);
    chk({tag, "_code"}, 32'(bus.o_error_code), 0);
    chk({tag, "_count"}, 32'(bus.o_instr_count), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prog[$];
    logic [4:0]  op;
    int          k, r;

    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    rst_n          = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    idle(2);
    check_all_zero("rst_idle");

    // Bytes in IDLE are ignored
    send_byte(8'h00);
    send_byte(8'h00);
    idle(2);
    check_all_zero("idle_ignore");

    // Basic three-word program ending in HALT
    do_start();
    prog = '{16'h1805, 16'h2803, 16'h0000};
    run_program("basic", prog, 2);

    // Bytes in DONE are ignored and status is held
    send_byte(8'h08);
    send_byte(8'h01);
    idle(2);
    check_status("done_hold", 1'b1, 1'b0, 2'b00, 3);

    // Illegal opcode 01001
    do_start();
    prog = '{16'h4800};
    run_program("badop", prog, 0);
    do_start();

    // Overflow: four non-HALT words fill the memory
    prog = '{16'h0801, 16'h1002, 16'h1803, 16'h2004};
    run_program("overflow", prog, 2);

    // Back-to-back bytes, next high byte on the WRITE cycle
    do_start();
    prog = '{16'h1001, 16'h0802, 16'h0000};
    run_program("write_cycle_byte", prog, 0);

    // Byte in the WRITE cycle of HALT is dropped
    do_start();
    exp_q.push_back('{addr: '0, data: 16'h0000});
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h08);
    idle(3);
    check_status("halt_drop", 1'b1, 1'b0, 2'b00, 1);

    // Timeout waiting for the low byte
    do_start();
    send_byte(8'h18);
    k = 0;
    while (bus.o_error !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    chk("tmo_lo_cycles", 32'(k), TMO);
    check_status("tmo_lo", 1'b0, 1'b1, 2'b11, 0);

    // Timeout waiting for the high byte
    do_start();
    k = 0;
    while (bus.o_error !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    chk("tmo_hi_cycles", 32'(k), TMO);
    check_status("tmo_hi", 1'b0, 1'b1, 2'b11, 0);

    // Byte on the terminal idle cycle is accepted (both byte positions)
    do_start();
    idle(TMO - 1);
    chk("tmo_edge_hi_noerr", 32'(bus.o_error), 0);
    exp_q.push_back('{addr: 2'd0, data: 16'h1807});
    send_byte(8'h18);
    idle(TMO - 1);
    chk("tmo_edge_lo_noerr", 32'(bus.o_error), 0);
    send_byte(8'h07);
    idle(1);
    prog = '{16'h0000};
    exp_q.push_back('{addr: 2'd1, data: 16'h0000});
    send_byte(8'h00);
    send_byte(8'h00);
    idle(3);
    check_status("tmo_edge", 1'b1, 1'b0, 2'b00, 2);

    // i_start while loading does not restart the load
    do_start();
    exp_q.push_back('{addr: 2'd0, data: 16'h0801});
    send_byte(8'h08);
    send_byte(8'h01);
    idle(1);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("start_ignored_busy", 32'(bus.o_busy), 1);
    exp_q.push_back('{addr: 2'd1, data: 16'h0000});
    send_byte(8'h00);
    send_byte(8'h00);
    idle(3);
    check_status("start_ignored", 1'b1, 1'b0, 2'b00, 2);

    // Asynchronous reset mid-load while waiting for a low byte
    do_start();
    exp_q.push_back('{addr: 2'd0, data: 16'h0801});
    send_byte(8'h08);
    send_byte(8'h01);
    idle(1);
    send_byte(8'h18);
    chk("pre_rst_count", 32'(bus.o_instr_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #4;
    rst_n = 1'b1;
    idle(3);
    check_all_zero("post_rst");
    chk("post_rst_writes_left", 32'(exp_q.size()), 0);

    // Randomized programs
    for (int it = 0; it < 30; it++) begin
      prog.delete();
      for (int i = 0; i < DEPTH; i++) begin
        r = $urandom_range(0, 19);
        if (r == 0)      op = 5'($urandom_range(8, 31));
        else if (r < 4)  op = 5'd0;
        else             op = 5'($urandom_range(1, 7));
        prog.push_back({op, 11'($urandom)});
      end
      do_start();
      idle($urandom_range(0, 3));
      run_program("rand", prog, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
